// File: rtl/loop_config_sequencer.sv
// loop_config_sequencer: config/launch sequencer for the SIMD nested-loop address generator.
// Ports:
//   clk, reset (sync, active-low)
//   instr_valid/instr_ready/instr_opcode/instr_loop_idx/instr_data : instruction handshake
//     opcode 0=SET_BASE 1=SET_ITER 2=SET_STRIDE 3=START
//   base, stride, num_iter : config registers to the generator (stride/num_iter packed per loop)
//   start_loop (pulse), in_nested_loop (level) : launch control to the generator
//   loop_done_in, address_valid_in : generator feedback
//   seq_done (pulse), addr_count, cfg_err (sticky), timeout_err (sticky) : status
// Optional: define LOOP_SEQ_WATCHDOG_EN to build the RUN-state watchdog (TIMEOUT_CYCLES).
module loop_config_sequencer #(
    parameter NUM_MAX_LOOPS     = 7,
    parameter LOG_NUM_MAX_LOOPS = 3,
    parameter BASE_WIDTH        = 32,
    parameter STRIDE_WIDTH      = BASE_WIDTH,
    parameter NUM_ITER_WIDTH    = 32,
    parameter DATA_WIDTH        = 32,
    parameter TIMEOUT_CYCLES    = 1048576
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    instr_valid,
    output logic                                    instr_ready,
    input  logic [1:0]                              instr_opcode,
    input  logic [LOG_NUM_MAX_LOOPS-1:0]            instr_loop_idx,
    input  logic [DATA_WIDTH-1:0]                   instr_data,
    output logic [BASE_WIDTH-1:0]                   base,
    output logic [STRIDE_WIDTH*NUM_MAX_LOOPS-1:0]   stride,
    output logic [NUM_ITER_WIDTH*NUM_MAX_LOOPS-1:0] num_iter,
    output logic                                    start_loop,
    output logic                                    in_nested_loop,
    input  logic                                    loop_done_in,
    input  logic                                    address_valid_in,
    output logic                                    seq_done,
    output logic [31:0]                             addr_count,
    output logic                                    cfg_err,
    output logic                                    timeout_err
);
    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, FINISH} state_t;

    if (DATA_WIDTH < BASE_WIDTH || DATA_WIDTH < STRIDE_WIDTH || DATA_WIDTH < NUM_ITER_WIDTH ||
        TIMEOUT_CYCLES < 1 || NUM_MAX_LOOPS > (1 << LOG_NUM_MAX_LOOPS)) begin : g_bad_params
        $error("loop_config_sequencer: illegal parameter combination");
    end

    state_t                              state_q, state_d;
    logic [BASE_WIDTH-1:0]               base_q, base_d;
    logic [STRIDE_WIDTH*NUM_MAX_LOOPS-1:0]   stride_q, stride_d;
    logic [NUM_ITER_WIDTH*NUM_MAX_LOOPS-1:0] num_iter_q, num_iter_d;
    logic                                start_loop_q, start_loop_d;
    logic                                in_nested_loop_q, in_nested_loop_d;
    logic                                seq_done_q, seq_done_d;
    logic                                instr_ready_q, instr_ready_d;
    logic                                cfg_err_q, cfg_err_d;
    logic [31:0]                         addr_count_q, addr_count_d;
    logic                                accept, idx_ok, wd_expired;

    assign accept = instr_valid && instr_ready_q;
    assign idx_ok = 32'(instr_loop_idx) < NUM_MAX_LOOPS;

`ifdef LOOP_SEQ_WATCHDOG_EN
    localparam WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_err_q, timeout_err_d;

    // Counter holds the number of RUN cycles already completed; it expires in the last allowed one.
    assign wd_expired = (state_q == RUN) && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wd_cnt_d      = (state_q == RUN) ? wd_cnt_q + WD_W'(1) : '0;
        timeout_err_d = timeout_err_q || (wd_expired && !loop_done_in);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign wd_expired  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        stride_d     = stride_q;
        num_iter_d   = num_iter_q;
        cfg_err_d    = cfg_err_q;
        addr_count_d = addr_count_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (instr_opcode)
                        2'd0: base_d = instr_data[BASE_WIDTH-1:0];
                        2'd1, 2'd2: begin
                            if (!idx_ok) cfg_err_d = 1'b1;
                            for (int i = 0; i < NUM_MAX_LOOPS; i++) begin
                                if (instr_loop_idx == LOG_NUM_MAX_LOOPS'(i)) begin
                                    if (instr_opcode == 2'd1)
                                        num_iter_d[i*NUM_ITER_WIDTH +: NUM_ITER_WIDTH] = instr_data[NUM_ITER_WIDTH-1:0];
                                    else
                                        stride_d[i*STRIDE_WIDTH +: STRIDE_WIDTH] = instr_data[STRIDE_WIDTH-1:0];
                                end
                            end
                        end
                        default: begin
                            addr_count_d = '0;
                            state_d      = LAUNCH;
                        end
                    endcase
                end
            end
            // loop_done_in is deliberately not looked at here.
            LAUNCH: state_d = RUN;
            RUN: begin
                if (address_valid_in && addr_count_q != '1) addr_count_d = addr_count_q + 32'd1;
                if (loop_done_in || wd_expired) state_d = FINISH;
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered: decode them from the state being entered.
        start_loop_d     = state_d == LAUNCH;
        in_nested_loop_d = state_d == LAUNCH || state_d == RUN;
        seq_done_d       = state_d == FINISH;
        instr_ready_d    = state_d == IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= IDLE;
            base_q           <= '0;
            stride_q         <= '0;
            num_iter_q       <= '0;
            start_loop_q     <= 1'b0;
            in_nested_loop_q <= 1'b0;
            seq_done_q       <= 1'b0;
            instr_ready_q    <= 1'b1;
            cfg_err_q        <= 1'b0;
            addr_count_q     <= '0;
        end else begin
            state_q          <= state_d;
            base_q           <= base_d;
            stride_q         <= stride_d;
            num_iter_q       <= num_iter_d;
            start_loop_q     <= start_loop_d;
            in_nested_loop_q <= in_nested_loop_d;
            seq_done_q       <= seq_done_d;
            instr_ready_q    <= instr_ready_d;
            cfg_err_q        <= cfg_err_d;
            addr_count_q     <= addr_count_d;
        end
    end

    assign instr_ready    = instr_ready_q;
    assign base           = base_q;
    assign stride         = stride_q;
    assign num_iter       = num_iter_q;
    assign start_loop     = start_loop_q;
    assign in_nested_loop = in_nested_loop_q;
    assign seq_done       = seq_done_q;
    assign addr_count     = addr_count_q;
    assign cfg_err        = cfg_err_q;
endmodule

// File: tb/tb_loop_config_sequencer.sv
// tb_loop_config_sequencer: directed self-checking bench for loop_config_sequencer.
module tb_loop_config_sequencer;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         instr_valid = 1'b0;
    logic         instr_ready;
    logic [1:0]   instr_opcode = 2'd0;
    logic [2:0]   instr_loop_idx = 3'd0;
    logic [31:0]  instr_data = 32'd0;
    logic [31:0]  base;
    logic [223:0] stride;
    logic [223:0] num_iter;
    logic         start_loop;
    logic         in_nested_loop;
    logic         loop_done_in = 1'b0;
    logic         address_valid_in = 1'b0;
    logic         seq_done;
    logic [31:0]  addr_count;
    logic         cfg_err;
    logic         timeout_err;
    int           n_checks = 0;
    int           n_fail = 0;
    logic [223:0] exp_iter;
    logic [223:0] exp_stride;

    loop_config_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_opcode(instr_opcode), .instr_loop_idx(instr_loop_idx), .instr_data(instr_data),
        .base(base), .stride(stride), .num_iter(num_iter),
        .start_loop(start_loop), .in_nested_loop(in_nested_loop),
        .loop_done_in(loop_done_in), .address_valid_in(address_valid_in),
        .seq_done(seq_done), .addr_count(addr_count),
        .cfg_err(cfg_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [2:0] idx, input logic [31:0] data);
        instr_valid    = 1'b1;
        instr_opcode   = op;
        instr_loop_idx = idx;
        instr_data     = data;
        tick();
        instr_valid    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        check("rst_ready", instr_ready, 1);
        check("rst_base", base, 0);
        check("rst_stride", stride, 0);
        check("rst_iter", num_iter, 0);
        check("rst_pulses", {start_loop, in_nested_loop, seq_done, cfg_err, timeout_err}, 0);
        check("rst_count", addr_count, 0);
        reset = 1'b1;
        tick();

        send(2'd0, 3'd0, 32'h100);
        send(2'd1, 3'd0, 32'd2);
        send(2'd1, 3'd1, 32'd3);
        send(2'd2, 3'd0, 32'h40);
        send(2'd2, 3'd1, 32'h4);
        send(2'd2, 3'd6, 32'h99);
        exp_iter   = '0;
        exp_iter[31:0] = 32'd2;
        exp_iter[63:32] = 32'd3;
        exp_stride = '0;
        exp_stride[31:0] = 32'h40;
        exp_stride[63:32] = 32'h4;
        exp_stride[223:192] = 32'h99;
        check("cfg_base", base, 32'h100);
        check("cfg_iter", num_iter, exp_iter);
        check("cfg_stride", stride, exp_stride);
        check("cfg_err_clean", cfg_err, 0);

        send(2'd1, 3'd7, 32'd5);
        check("oor_iter", num_iter, exp_iter);
        check("oor_stride", stride, exp_stride);
        check("oor_err", cfg_err, 1);

        // Run 1: done held in LAUNCH must be ignored, then 6 addresses, then done.
        send(2'd3, 3'd0, 32'd0);
        check("launch_ctl", {start_loop, in_nested_loop, instr_ready, seq_done}, 4'b1100);
        loop_done_in = 1'b1;
        tick();
        loop_done_in = 1'b0;
        check("run_ctl", {start_loop, in_nested_loop, instr_ready, seq_done}, 4'b0100);
        address_valid_in = 1'b1;
        repeat (6) tick();
        address_valid_in = 1'b0;
        check("run_count", addr_count, 6);
        check("run_still", in_nested_loop, 1);
        loop_done_in = 1'b1;
        tick();
        loop_done_in = 1'b0;
        check("finish_ctl", {start_loop, in_nested_loop, instr_ready, seq_done}, 4'b0001);
        check("finish_count", addr_count, 6);
        tick();
        check("idle_ctl", {start_loop, in_nested_loop, instr_ready, seq_done}, 4'b0010);
        check("idle_count", addr_count, 6);
        check("err_sticky", cfg_err, 1);

        // Run 2: back-to-back START, busy write ignored, valid+done together.
        send(2'd3, 3'd0, 32'd0);
        check("r2_clear", addr_count, 0);
        check("r2_start", start_loop, 1);
        tick();
        instr_valid      = 1'b1;
        instr_opcode     = 2'd0;
        instr_data       = 32'h55;
        address_valid_in = 1'b1;
        loop_done_in     = 1'b1;
        tick();
        instr_valid      = 1'b0;
        address_valid_in = 1'b0;
        loop_done_in     = 1'b0;
        check("r2_count", addr_count, 1);
        check("r2_done", seq_done, 1);
        tick();
        check("r2_base_kept", base, 32'h100);
        check("r2_ready", instr_ready, 1);
        check("r2_err_sticky", cfg_err, 1);

        // Reset during RUN.
        send(2'd3, 3'd0, 32'd0);
        tick();
        address_valid_in = 1'b1;
        tick();
        check("mr_count_pre", addr_count, 1);
        reset = 1'b0;
        tick();
        check("mr_ctl", {start_loop, in_nested_loop, instr_ready, seq_done}, 4'b0010);
        check("mr_count", addr_count, 0);
        check("mr_cfg", {base, cfg_err}, 0);
        reset = 1'b1;
        address_valid_in = 1'b0;
        tick();
        check("mr_no_done", seq_done, 0);
        check("mr_idle", instr_ready, 1);

        // No done from the generator: watchdog ends the run only when built in.
        send(2'd3, 3'd0, 32'd0);
        tick();
`ifdef LOOP_SEQ_WATCHDOG_EN
        begin
            int n;
            n = 0;
            while (!seq_done && n < 40) begin
                tick();
                n++;
            end
            check("wd_cycles", n, 16);
            check("wd_err", timeout_err, 1);
            check("wd_nested", in_nested_loop, 0);
            tick();
            check("wd_idle", instr_ready, 1);
            check("wd_err_sticky", timeout_err, 1);
        end
`else
        repeat (20) tick();
        check("nowd_waiting", {in_nested_loop, seq_done, instr_ready}, 3'b100);
        check("nowd_err", timeout_err, 0);
        loop_done_in = 1'b1;
        tick();
        loop_done_in = 1'b0;
        check("nowd_done", seq_done, 1);
        tick();
        check("nowd_idle", instr_ready, 1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/loop_config_sequencer.md
Name: loop_config_sequencer

Overview:
- Upstream driver for the SIMD nested-loop address generator.
- Accepts configuration/launch instructions over a valid/ready interface and holds the per-loop base, stride and iteration registers.
- Issues the one-cycle start pulse and holds the loop-active level, then waits for the generator's done indication.
- Reports completion and an address count back to the issuing controller.

Parameters:
- NUM_MAX_LOOPS, 7, number of loop levels driven.
- LOG_NUM_MAX_LOOPS, 3, width of the loop index field.
- BASE_WIDTH, 32, base address width.
- STRIDE_WIDTH, BASE_WIDTH, per-loop stride width.
- NUM_ITER_WIDTH, 32, per-loop iteration count width.
- DATA_WIDTH, 32, instruction payload width; must be >= max(BASE_WIDTH, STRIDE_WIDTH, NUM_ITER_WIDTH).
- TIMEOUT_CYCLES, 1048576, watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (reset==0 resets).
- instr_valid  in  1  instruction present.
- instr_ready  out  1  sequencer can accept an instruction.
- instr_opcode  in  2  0=SET_BASE, 1=SET_ITER, 2=SET_STRIDE, 3=START.
- instr_loop_idx  in  LOG_NUM_MAX_LOOPS  target loop level (SET_ITER/SET_STRIDE only).
- instr_data  in  DATA_WIDTH  payload, zero-extended/truncated to the field width.
- base  out  BASE_WIDTH  base address to the generator.
- stride  out  STRIDE_WIDTH*NUM_MAX_LOOPS  packed strides; loop i occupies [i*STRIDE_WIDTH +: STRIDE_WIDTH].
- num_iter  out  NUM_ITER_WIDTH*NUM_MAX_LOOPS  packed iteration counts, same packing as stride.
- start_loop  out  1  one-cycle launch pulse.
- in_nested_loop  out  1  level, high while a loop is active.
- loop_done_in  in  1  generator done indication.
- address_valid_in  in  1  generator address strobe.
- seq_done  out  1  one-cycle completion pulse.
- addr_count  out  32  addresses counted in the last/current run.
- cfg_err  out  1  sticky: a SET_ITER/SET_STRIDE arrived with loop_idx >= NUM_MAX_LOOPS.
- timeout_err  out  1  sticky watchdog flag; tied 0 when the optional feature is excluded.

Behaviour:
- Reset values: all config registers 0; outputs start_loop, in_nested_loop, seq_done, cfg_err, timeout_err 0; addr_count 0; instr_ready 1; state IDLE.
- An instruction transfers on instr_valid && instr_ready. Registers update on the next edge.
- FSM states:
  - IDLE: instr_ready=1.
    - SET_BASE writes base.
    - SET_ITER/SET_STRIDE write num_iter[idx] or stride[idx].
    - Out-of-range idx writes nothing and sets cfg_err.
    - START clears addr_count and moves to LAUNCH.
  - LAUNCH (1 cycle): start_loop=1, in_nested_loop=1, instr_ready=0. Next state is RUN.
  - RUN: in_nested_loop=1, instr_ready=0. addr_count increments on each address_valid_in. When loop_done_in is seen (sampled from the first RUN cycle), go to FINISH.
  - FINISH (1 cycle): in_nested_loop=0, seq_done=1, instr_ready=0. Next state is IDLE.
- Config outputs are stable throughout LAUNCH/RUN/FINISH. Writes are impossible there because instr_ready=0.
- in_nested_loop falls to 0 for at least one cycle between runs, which resets the generator's run counter.
- Back-to-back START: instr_ready returns to 1 in the IDLE cycle after FINISH. Minimum START-to-START spacing is 4 cycles when RUN lasts 1 cycle.
- loop_done_in asserted in the LAUNCH cycle is ignored.
- loop_done_in and address_valid_in in the same RUN cycle: the count increments, then the FSM exits.
- num_iter==0 for a level is passed through unchanged.
- addr_count saturates at 0xFFFFFFFF and holds after FINISH until the next START.
- Reset mid-run (reset==0 in any state) returns the block to IDLE with reset values in one edge. start_loop/in_nested_loop drop immediately at that edge.
- cfg_err clears only on reset.

Optional Feature:
- Macro LOOP_SEQ_WATCHDOG_EN.
- Defined:
  - A cycle counter runs in RUN.
  - Reaching TIMEOUT_CYCLES without loop_done_in sets timeout_err (sticky until reset) and forces FINISH. seq_done still pulses.
- Undefined: no counter is built; timeout_err is tied 0; RUN waits indefinitely.

Test Plan:
- Reset: hold reset=0 for 3 cycles -> instr_ready=1; base=0, stride=0, num_iter=0; all pulses 0.
- Config: SET_BASE 0x100, SET_ITER idx0=2, idx1=3, SET_STRIDE idx0=0x40, idx1=0x4 -> base=0x100, num_iter[31:0]=2, num_iter[63:32]=3, stride[31:0]=0x40, stride[63:32]=0x4.
- Run: START, model asserts address_valid_in for 6 cycles then loop_done_in -> start_loop high exactly 1 cycle after the START handshake; in_nested_loop high from LAUNCH to the last RUN cycle; seq_done single pulse; addr_count=6; instr_ready=1 the following cycle.
- Error: SET_ITER idx=7 data=5 -> no num_iter change; cfg_err=1 and stays 1 after a subsequent valid run.
- Reset mid-run: reset=0 during RUN -> next cycle in IDLE; in_nested_loop=0, addr_count=0, no seq_done.
- Watchdog (macro defined, TIMEOUT_CYCLES=16): START, never assert loop_done_in -> after 16 RUN cycles timeout_err=1, seq_done pulses, back in IDLE.
